exu_div_sched: RTL and testbench
================================

Name: exu_div_sched

Overview:
- In-order issue scheduler between the decode stage (idu1) and the execution units.
- Each decoded instruction goes either to the single-cycle ALU or to a shared multi-cycle iterative divider (eBPF DIV/MOD).
- Tracks the one outstanding divide in a scoreboard and stalls decode on structural, RAW and WAW hazards.
- Arbitrates the single register-file write port between ALU writeback and divider completion.

Parameters:
- XLEN, 64, datapath width of the write data.
- REG_FILE_ADDR_WIDTH, 4, register address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- dec_valid  input  1  decode holds a legal, non-nop instruction
- dec_ready  output  1  scheduler accepts the decode instruction this cycle
- dec_is_div  input  1  instruction targets the divider
- dec_rd_wr  input  1  instruction writes rd
- dec_rd_addr  input  REG_FILE_ADDR_WIDTH  destination register
- dec_rs1_vld / dec_rs2_vld  input  1 each  source register is used
- dec_rs1_addr / dec_rs2_addr  input  REG_FILE_ADDR_WIDTH each  source registers
- flush  input  1  taken branch/jump (registered ALU pc_load)
- alu_issue  output  1  qualifies the ALU's legal/alu enable
- div_start  output  1  one-cycle start pulse to the divider
- div_done  input  1  one-cycle divider completion pulse
- div_result  input  XLEN  divider result, valid with div_done
- alu_wb_rd_wr_en  input  1  registered ALU writeback enable
- alu_wb_rd_addr  input  REG_FILE_ADDR_WIDTH  ALU writeback address
- alu_wb_data  input  XLEN  ALU writeback data
- rf_wr_en  output  1  register-file write enable
- rf_wr_addr  output  REG_FILE_ADDR_WIDTH  register-file write address
- rf_wr_data  output  XLEN  register-file write data
- div_pending  output  1  a divide is outstanding (state != IDLE)

Behaviour:
- Reset (synchronous, rst=1):
  - state=IDLE; pend_rd=0; hold_data=0.
  - div_pending=0, div_start=0, alu_issue=0, rf_wr_en=0.
  - A div_done arriving in IDLE is ignored.
- Issue: fire = dec_valid & dec_ready & ~flush; alu_issue = fire & ~dec_is_div; div_start = fire & dec_is_div. On div_start, pend_rd <= dec_rd_addr.
- Flush: with flush=1, dec_ready=1 and the decode instruction is dropped (no issue). The outstanding divide is older than the branch, so it continues unaffected.
- dec_ready = 0 (stall) when any of the following hold:
  - dec_is_div and state != IDLE (structural).
  - state != IDLE and a valid rs1/rs2 equals pend_rd (RAW).
  - state != IDLE and dec_rd_wr and dec_rd_addr == pend_rd (WAW).
  - state == HOLD (port drain).
- FSM:
  - IDLE: div_start -> BUSY.
  - BUSY: div_done & ~alu_wb_rd_wr_en -> IDLE, and the divider writes this cycle.
  - BUSY: div_done & alu_wb_rd_wr_en -> HOLD, hold_data <= div_result.
  - HOLD: ~alu_wb_rd_wr_en -> IDLE, and hold_data is written this cycle.
  - HOLD lasts at most 2 cycles, because issue is blocked in HOLD.
- Write-port mux (combinational, ALU has priority):
  - alu_wb_rd_wr_en=1 -> ALU address/data.
  - Otherwise, BUSY&div_done -> pend_rd/div_result; HOLD -> pend_rd/hold_data.
  - Otherwise rf_wr_en=0.
- Simultaneous events:
  - div_done in the same cycle as a decode RAW on pend_rd: decode still stalls that cycle and is released the cycle after the register-file write.
  - div_start is impossible in the same cycle as div_done (structural stall).
- The divider is never restarted while busy. At most one divide is outstanding.

Optional Feature:
- EXU_DIV_SCHED_ALU_RAW_STALL_EN
  - Defined: the scheduler also registers the last ALU issue's rd (alu_rd_q, valid for 1 cycle when rd written). A decode source matching alu_rd_q stalls dec_ready for exactly one cycle.
  - Undefined: no ALU interlock; the ALU-to-consumer bypass network handles the dependency.

Test Plan:
- Reset then ALU ADD r1 (dec_valid=1, is_div=0, rd=1) -> alu_issue=1 same cycle; next cycle ALU wb rd=1 passes to rf_wr_en=1, rf_wr_addr=1.
- DIV r3 issued, divider done after 8 cycles with result 0x2A, no ALU traffic -> div_pending=1 for 8 cycles; rf_wr_en=1, addr=3, data=0x2A in the done cycle; then IDLE.
- DIV r3 pending, then ADD r4=r3+r2 -> dec_ready=0 until the cycle after the r3 write; ADD with sources r5,r6 issues without stall while the divide runs.
- div_done coincides with ALU wb to r7 -> r7 written first; next cycle rf_wr_addr=3 with hold_data; state HOLD, dec_ready=0 for that one cycle.
- flush=1 with a valid DIV in decode -> div_start=0, dec_ready=1, div_pending unchanged; a second DIV while BUSY stalls.
- rst=1 asserted mid-BUSY -> div_pending=0 next cycle; a later div_done produces no write.

Source files
------------

// File: rtl/exu_div_sched.sv
// In-order issue scheduler: steers decode to the ALU or the shared iterative divider,
// tracks the single outstanding divide and arbitrates the register-file write port.
// Optional define EXU_DIV_SCHED_ALU_RAW_STALL_EN adds a one-cycle ALU-to-consumer interlock.
module exu_div_sched #(
    parameter int XLEN                = 64,
    parameter int REG_FILE_ADDR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           dec_valid,
    output logic                           dec_ready,
    input  logic                           dec_is_div,
    input  logic                           dec_rd_wr,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dec_rd_addr,
    input  logic                           dec_rs1_vld,
    input  logic                           dec_rs2_vld,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dec_rs1_addr,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dec_rs2_addr,
    input  logic                           flush,
    output logic                           alu_issue,
    output logic                           div_start,
    input  logic                           div_done,
    input  logic [XLEN-1:0]                div_result,
    input  logic                           alu_wb_rd_wr_en,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] alu_wb_rd_addr,
    input  logic [XLEN-1:0]                alu_wb_data,
    output logic                           rf_wr_en,
    output logic [REG_FILE_ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [XLEN-1:0]                rf_wr_data,
    output logic                           div_pending
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_t;

    state_t                         state;
    logic [REG_FILE_ADDR_WIDTH-1:0] pend_rd;
    logic [XLEN-1:0]                hold_data;

    logic busy;
    logic structural_hz;
    logic raw_hz;
    logic waw_hz;
    logic drain_hz;
    logic alu_raw_hz;
    logic stall;
    logic fire;

    assign busy          = (state != IDLE);
    assign structural_hz = dec_is_div & busy;
    assign raw_hz        = busy & ((dec_rs1_vld & (dec_rs1_addr == pend_rd)) |
                                   (dec_rs2_vld & (dec_rs2_addr == pend_rd)));
    assign waw_hz        = busy & dec_rd_wr & (dec_rd_addr == pend_rd);
    assign drain_hz      = (state == HOLD);

`ifdef EXU_DIV_SCHED_ALU_RAW_STALL_EN
    logic                           alu_rd_vld_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] alu_rd_q;

    // Destination of the previous ALU issue; only lives for the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_rd_vld_q <= 1'b0;
            alu_rd_q     <= '0;
        end else begin
            alu_rd_vld_q <= alu_issue & dec_rd_wr;
            if (alu_issue & dec_rd_wr) begin
                alu_rd_q <= dec_rd_addr;
            end
        end
    end

    assign alu_raw_hz = alu_rd_vld_q & ((dec_rs1_vld & (dec_rs1_addr == alu_rd_q)) |
                                        (dec_rs2_vld & (dec_rs2_addr == alu_rd_q)));
`else
    assign alu_raw_hz = 1'b0;
`endif

    assign stall = structural_hz | raw_hz | waw_hz | drain_hz | alu_raw_hz;

    // A flushed decode slot is always consumed so the wrong-path instruction drains away.
    assign dec_ready   = flush | ~stall;
    assign fire        = dec_valid & dec_ready & ~flush & ~rst;
    assign alu_issue   = fire & ~dec_is_div;
    assign div_start   = fire & dec_is_div;
    assign div_pending = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend_rd   <= '0;
            hold_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        state   <= BUSY;
                        pend_rd <= dec_rd_addr;
                    end
                end
                BUSY: begin
                    if (div_done) begin
                        if (alu_wb_rd_wr_en) begin
                            state     <= HOLD;
                            hold_data <= div_result;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (!alu_wb_rd_wr_en) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ALU writeback owns the port; divider results wait in hold_data when they collide.
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        if (!rst) begin
            if (alu_wb_rd_wr_en) begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = alu_wb_rd_addr;
                rf_wr_data = alu_wb_data;
            end else if ((state == BUSY) && div_done) begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = pend_rd;
                rf_wr_data = div_result;
            end else if (state == HOLD) begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = pend_rd;
                rf_wr_data = hold_data;
            end
        end
    end

endmodule

// File: tb/tb_exu_div_sched.sv
// Cycle-by-cycle vector bench for exu_div_sched with a queue of expected register-file writes.
module tb_exu_div_sched;

    localparam int XLEN = 64;
    localparam int AW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            dec_valid;
    logic            dec_ready;
    logic            dec_is_div;
    logic            dec_rd_wr;
    logic [AW-1:0]   dec_rd_addr;
    logic            dec_rs1_vld;
    logic            dec_rs2_vld;
    logic [AW-1:0]   dec_rs1_addr;
    logic [AW-1:0]   dec_rs2_addr;
    logic            flush;
    logic            alu_issue;
    logic            div_start;
    logic            div_done;
    logic [XLEN-1:0] div_result;
    logic            alu_wb_rd_wr_en;
    logic [AW-1:0]   alu_wb_rd_addr;
    logic [XLEN-1:0] alu_wb_data;
    logic            rf_wr_en;
    logic [AW-1:0]   rf_wr_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic            div_pending;

    always #5 clk = ~clk;

    exu_div_sched #(.XLEN(XLEN), .REG_FILE_ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_is_div     (dec_is_div),
        .dec_rd_wr      (dec_rd_wr),
        .dec_rd_addr    (dec_rd_addr),
        .dec_rs1_vld    (dec_rs1_vld),
        .dec_rs2_vld    (dec_rs2_vld),
        .dec_rs1_addr   (dec_rs1_addr),
        .dec_rs2_addr   (dec_rs2_addr),
        .flush          (flush),
        .alu_issue      (alu_issue),
        .div_start      (div_start),
        .div_done       (div_done),
        .div_result     (div_result),
        .alu_wb_rd_wr_en(alu_wb_rd_wr_en),
        .alu_wb_rd_addr (alu_wb_rd_addr),
        .alu_wb_data    (alu_wb_data),
        .rf_wr_en       (rf_wr_en),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wr_data     (rf_wr_data),
        .div_pending    (div_pending)
    );

    typedef struct packed {
        logic            rst;
        logic            valid;
        logic            is_div;
        logic            rd_wr;
        logic [AW-1:0]   rd;
        logic            rs1_vld;
        logic [AW-1:0]   rs1;
        logic            rs2_vld;
        logic [AW-1:0]   rs2;
        logic            flush;
        logic            done;
        logic [XLEN-1:0] result;
        logic            wb_en;
        logic [AW-1:0]   wb_addr;
        logic [XLEN-1:0] wb_data;
        logic            exp_ready;
        logic            exp_alu;
        logic            exp_start;
        logic            exp_pend;
        logic            exp_wr;
        logic [AW-1:0]   exp_addr;
        logic [XLEN-1:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic vec_t idle(input logic pend);
        vec_t t;
        t           = '0;
        t.exp_ready = 1'b1;
        t.exp_pend  = pend;
        return t;
    endfunction

    function automatic vec_t alu(input logic [AW-1:0] rd, input logic s1v, input logic [AW-1:0] s1,
                                 input logic s2v, input logic [AW-1:0] s2, input logic pend);
        vec_t t;
        t         = idle(pend);
        t.valid   = 1'b1;
        t.rd_wr   = 1'b1;
        t.rd      = rd;
        t.rs1_vld = s1v;
        t.rs1     = s1;
        t.rs2_vld = s2v;
        t.rs2     = s2;
        t.exp_alu = 1'b1;
        return t;
    endfunction

    function automatic vec_t div(input logic [AW-1:0] rd, input logic pend);
        vec_t t;
        t           = idle(pend);
        t.valid     = 1'b1;
        t.is_div    = 1'b1;
        t.rd_wr     = 1'b1;
        t.rd        = rd;
        t.rs1_vld   = 1'b1;
        t.rs1       = 4'd14;
        t.rs2_vld   = 1'b1;
        t.rs2       = 4'd15;
        t.exp_start = 1'b1;
        return t;
    endfunction

    function automatic vec_t drive_done(input vec_t t_in, input logic [XLEN-1:0] res);
        vec_t t;
        t        = t_in;
        t.done   = 1'b1;
        t.result = res;
        return t;
    endfunction

    function automatic vec_t drive_wb(input vec_t t_in, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        vec_t t;
        t         = t_in;
        t.wb_en   = 1'b1;
        t.wb_addr = a;
        t.wb_data = d;
        return t;
    endfunction

    function automatic vec_t expect_wr(input vec_t t_in, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        vec_t t;
        t          = t_in;
        t.exp_wr   = 1'b1;
        t.exp_addr = a;
        t.exp_data = d;
        return t;
    endfunction

    function automatic vec_t stalled(input vec_t t_in);
        vec_t t;
        t           = t_in;
        t.exp_ready = 1'b0;
        t.exp_alu   = 1'b0;
        t.exp_start = 1'b0;
        return t;
    endfunction

    task automatic compare(input string what, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        @(posedge clk);
        #1;
        rst             = t.rst;
        dec_valid       = t.valid;
        dec_is_div      = t.is_div;
        dec_rd_wr       = t.rd_wr;
        dec_rd_addr     = t.rd;
        dec_rs1_vld     = t.rs1_vld;
        dec_rs1_addr    = t.rs1;
        dec_rs2_vld     = t.rs2_vld;
        dec_rs2_addr    = t.rs2;
        flush           = t.flush;
        div_done        = t.done;
        div_result      = t.result;
        alu_wb_rd_wr_en = t.wb_en;
        alu_wb_rd_addr  = t.wb_addr;
        alu_wb_data     = t.wb_data;
        if (t.exp_wr) sb.push_back({t.exp_addr, t.exp_data});
    endtask

    task automatic checkOutput(input vec_t t, input int id);
        wr_t w;
        @(negedge clk);
        compare($sformatf("row%0d dec_ready", id),   64'(dec_ready),   64'(t.exp_ready));
        compare($sformatf("row%0d alu_issue", id),   64'(alu_issue),   64'(t.exp_alu));
        compare($sformatf("row%0d div_start", id),   64'(div_start),   64'(t.exp_start));
        compare($sformatf("row%0d div_pending", id), 64'(div_pending), 64'(t.exp_pend));
        compare($sformatf("row%0d rf_wr_en", id),    64'(rf_wr_en),    64'(t.exp_wr));
        if (rf_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL row%0d unexpected write: got addr %0d data 0x%0h, expected none",
                         id, rf_wr_addr, rf_wr_data);
            end else begin
                w = sb.pop_front();
                compare($sformatf("row%0d rf_wr_addr", id), 64'(rf_wr_addr), 64'(w.addr));
                compare($sformatf("row%0d rf_wr_data", id), rf_wr_data, w.data);
            end
        end else if (t.exp_wr && sb.size() > 0) begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t t;
        int   lat;

        // Reset with garbage on decode and ALU writeback; nothing may issue or write.
        t = alu(4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        t.rst = 1'b1;
        t.exp_alu = 1'b0;
        t = drive_wb(t, 4'd5, 64'hDEAD);
        vecs.push_back(t);
        vecs.push_back(alu(4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0));
        vecs.push_back(expect_wr(drive_wb(idle(1'b0), 4'd1, 64'h11), 4'd1, 64'h11));

        // DIV r3 with an 8-cycle divider, no ALU traffic.
        vecs.push_back(div(4'd3, 1'b0));
        for (int i = 0; i < 7; i++) vecs.push_back(idle(1'b1));
        vecs.push_back(expect_wr(drive_done(idle(1'b1), 64'h2A), 4'd3, 64'h2A));
        vecs.push_back(idle(1'b0));

        // Independent ADD flows; WAW and RAW on r3 stall until after the r3 write.
        vecs.push_back(div(4'd3, 1'b0));
        vecs.push_back(alu(4'd8, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1));
        vecs.push_back(stalled(alu(4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1)));
        vecs.push_back(stalled(alu(4'd4, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1)));
        vecs.push_back(expect_wr(drive_done(stalled(alu(4'd4, 1'b1, 4'd3, 1'b1, 4'd2, 1'b1)), 64'h33),
                                 4'd3, 64'h33));
        vecs.push_back(alu(4'd4, 1'b1, 4'd3, 1'b1, 4'd2, 1'b0));

        // Completion collides with ALU writeback to r7: ALU first, then the held result.
        vecs.push_back(div(4'd3, 1'b0));
        vecs.push_back(idle(1'b1));
        vecs.push_back(expect_wr(drive_wb(drive_done(idle(1'b1), 64'h44), 4'd7, 64'h77), 4'd7, 64'h77));
        vecs.push_back(expect_wr(stalled(alu(4'd9, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1)), 4'd3, 64'h44));
        vecs.push_back(alu(4'd9, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0));

        // Two back-to-back ALU writebacks stretch HOLD to two cycles.
        vecs.push_back(div(4'd2, 1'b0));
        vecs.push_back(expect_wr(drive_wb(drive_done(idle(1'b1), 64'h55), 4'd10, 64'hA0), 4'd10, 64'hA0));
        vecs.push_back(expect_wr(stalled(drive_wb(idle(1'b1), 4'd11, 64'hB0)), 4'd11, 64'hB0));
        vecs.push_back(expect_wr(stalled(idle(1'b1)), 4'd2, 64'h55));
        vecs.push_back(idle(1'b0));

        // Flush drops a DIV without disturbing the running one; a second DIV stalls.
        vecs.push_back(div(4'd6, 1'b0));
        t = div(4'd5, 1'b1);
        t.flush = 1'b1;
        t.exp_start = 1'b0;
        vecs.push_back(t);
        vecs.push_back(stalled(div(4'd5, 1'b1)));
        vecs.push_back(expect_wr(drive_done(stalled(div(4'd5, 1'b1)), 64'h66), 4'd6, 64'h66));
        vecs.push_back(div(4'd5, 1'b0));
        vecs.push_back(idle(1'b1));

        // Reset mid-BUSY; the late completion must not write.
        t = idle(1'b1);
        t.rst = 1'b1;
        vecs.push_back(t);
        vecs.push_back(idle(1'b0));
        vecs.push_back(drive_done(idle(1'b0), 64'h99));
        vecs.push_back(alu(4'd1, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0));
        t = alu(4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        t.flush = 1'b0;
        t.flush = 1'b1;
        t.exp_alu = 1'b0;
        vecs.push_back(t);

        rst             = 1'b1;
        dec_valid       = 1'b0;
        dec_is_div      = 1'b0;
        dec_rd_wr       = 1'b0;
        dec_rd_addr     = '0;
        dec_rs1_vld     = 1'b0;
        dec_rs1_addr    = '0;
        dec_rs2_vld     = 1'b0;
        dec_rs2_addr    = '0;
        flush           = 1'b0;
        div_done        = 1'b0;
        div_result      = '0;
        alu_wb_rd_wr_en = 1'b0;
        alu_wb_rd_addr  = '0;
        alu_wb_data     = '0;
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Variable divider latency with a dependent ADD waiting in decode.
        for (int k = 0; k < 3; k++) begin
            lat = (k == 0) ? 1 : $urandom_range(20, 3);
            applyStimulus(div(4'd12, 1'b0));
            checkOutput(div(4'd12, 1'b0), 1000 * (k + 1));
            for (int c = 1; c <= lat + 1; c++) begin
                if (c <= lat) begin
                    t = stalled(alu(4'd4, 1'b1, 4'd12, 1'b0, 4'd0, 1'b1));
                    if (c == lat) t = expect_wr(drive_done(t, 64'(lat) * 3), 4'd12, 64'(lat) * 3);
                end else begin
                    t = alu(4'd4, 1'b1, 4'd12, 1'b0, 4'd0, 1'b0);
                end
                applyStimulus(t);
                checkOutput(t, 1000 * (k + 1) + c);
            end
        end

        applyStimulus(idle(1'b0));
        checkOutput(idle(1'b0), 9999);
        compare("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
